// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register addresses, SR/Cause field positions, ExcCodes and the
// handler entry point used by the fetch PC unit.
package cp0_exc_unit_pkg;

  localparam int unsigned IM_WIDTH = 6;

  localparam logic [4:0] CP0_SR_ADDR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE_ADDR = 5'd13;
  localparam logic [4:0] CP0_EPC_ADDR   = 5'd14;
  localparam logic [4:0] CP0_PRID_ADDR  = 5'd15;

  // SR field positions
  localparam int unsigned SR_IM_LSB = 10;
  localparam int unsigned SR_EXL    = 1;
  localparam int unsigned SR_IE     = 0;

  // Cause field positions
  localparam int unsigned CAUSE_BD      = 31;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;

  typedef enum logic [4:0] {
    ExcInt  = 5'd0,
    ExcAdEL = 5'd4,
    ExcAdES = 5'd5,
    ExcRi   = 5'd10,
    ExcOv   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// M-stage <-> CP0 signal bundle: mfc0/mtc0 access, victim info, interrupts and the
// redirect/eret outputs towards the fetch PC unit.
interface cp0_exc_unit_if;
  import cp0_exc_unit_pkg::*;

  logic                we;
  logic [4:0]          cp0_addr;
  logic [31:0]         cp0_wdata;
  logic [31:0]         cp0_rdata;
  logic [31:0]         vpc;
  logic                bd_in;
  logic [4:0]          exc_code_in;
  logic [IM_WIDTH-1:0] hw_int;
  logic                exl_clr;
  logic                req;
  logic [31:0]         epc_out;

  modport master (
    output we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    input  cp0_rdata, req, epc_out
  );

  modport slave (
    input  we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    output cp0_rdata, req, epc_out
  );

endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller: holds SR/Cause/EPC, raises the fetch redirect request
// and supplies the eret return address.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2022
) (
  input logic            clk,
  input logic            reset,
  cp0_exc_unit_if.slave  cp0
);

  logic [IM_WIDTH-1:0] r_sr_im;
  logic                r_sr_exl;
  logic                r_sr_ie;
  logic                r_cause_bd;
  logic [IM_WIDTH-1:0] r_cause_ip;
  logic [4:0]          r_cause_exc;
  logic [31:0]         r_epc;

  logic        w_int_pend;
  logic        w_exc_pend;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_vpc_al;
  logic [31:0] w_victim_epc;
  logic [31:0] w_wdata_al;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        unused_vpc_lo;

  assign unused_vpc_lo = ^cp0.vpc[1:0];

  assign w_int_pend = (|(cp0.hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_pend = (cp0.exc_code_in != 5'd0) & ~r_sr_exl;
  // Gated by reset so a pending exc_code_in cannot redirect fetch while held in reset.
  assign w_req      = reset & (w_int_pend | w_exc_pend);

  assign w_wr_sr  = cp0.we & ~w_req & (cp0.cp0_addr == CP0_SR_ADDR);
  assign w_wr_epc = cp0.we & ~w_req & (cp0.cp0_addr == CP0_EPC_ADDR);

  assign w_vpc_al     = {cp0.vpc[31:2], 2'b00};
  assign w_victim_epc = cp0.bd_in ? (w_vpc_al - 32'd4) : w_vpc_al;
  assign w_wdata_al   = {cp0.cp0_wdata[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr_im     <= '0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= '0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'd0;
    end else begin
      r_cause_ip <= cp0.hw_int;
      if (w_req) begin
        r_sr_exl    <= 1'b1;
        r_cause_exc <= w_int_pend ? ExcInt : cp0.exc_code_in;
        r_cause_bd  <= cp0.bd_in;
        r_epc       <= w_victim_epc;
      end else begin
        if (cp0.exl_clr) r_sr_exl <= 1'b0;
        // An mtc0 to SR in the same cycle as eret overrides the eret clear.
        if (w_wr_sr) begin
          r_sr_im  <= cp0.cp0_wdata[SR_IM_LSB +: IM_WIDTH];
          r_sr_exl <= cp0.cp0_wdata[SR_EXL];
          r_sr_ie  <= cp0.cp0_wdata[SR_IE];
        end
        if (w_wr_epc) r_epc <= w_wdata_al;
      end
    end
  end

  always_comb begin
    w_sr                              = 32'd0;
    w_sr[SR_IM_LSB +: IM_WIDTH]       = r_sr_im;
    w_sr[SR_EXL]                      = r_sr_exl;
    w_sr[SR_IE]                       = r_sr_ie;
    w_cause                           = 32'd0;
    w_cause[CAUSE_BD]                 = r_cause_bd;
    w_cause[CAUSE_IP_LSB +: IM_WIDTH] = r_cause_ip;
    w_cause[CAUSE_EXC_LSB +: 5]       = r_cause_exc;
  end

  always_comb begin
    cp0.cp0_rdata = 32'd0;
    unique case (cp0.cp0_addr)
      CP0_SR_ADDR:    cp0.cp0_rdata = w_sr;
      CP0_CAUSE_ADDR: cp0.cp0_rdata = w_cause;
      CP0_EPC_ADDR:   cp0.cp0_rdata = r_epc;
      CP0_PRID_ADDR:  cp0.cp0_rdata = PRID;
      default:        cp0.cp0_rdata = 32'd0;
    endcase
  end

  assign cp0.req = w_req;
  // Forwarding lets an eret pick up an EPC written by mtc0 in the same cycle.
  assign cp0.epc_out = !reset   ? 32'd0 :
                       w_wr_epc ? w_wdata_al : r_epc;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios plus random traffic against a word-level
// reference model of the CP0 registers.
module tb_cp0_exc_unit;
  import cp0_exc_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  cp0_exc_unit_if cp0 ();

  cp0_exc_unit #(.PRID(32'h0000_2022)) dut (
    .clk   (clk),
    .reset (reset),
    .cp0   (cp0)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_int_pend();
    return (|(cp0.hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return reset && (m_int_pend() || (cp0.exc_code_in != 5'd0 && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_rdata();
    case (cp0.cp0_addr)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_2022;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_out();
    if (!reset) return 32'd0;
    if (cp0.we && !m_req() && cp0.cp0_addr == 5'd14) return cp0.cp0_wdata & ~32'd3;
    return m_epc;
  endfunction

  task automatic m_reset();
    m_sr = 32'd0;
    m_cause = 32'd0;
    m_epc = 32'd0;
  endtask

  // Applies one clock edge worth of architectural effect.
  task automatic m_step();
    logic        take, intr;
    logic [31:0] pc;
    take = m_req();
    intr = m_int_pend();
    if (take) begin
      m_sr = m_sr | 32'h2;
      m_cause = {cp0.bd_in, 15'd0, cp0.hw_int, 3'd0, (intr ? 5'd0 : cp0.exc_code_in), 2'd0};
      pc = cp0.vpc & ~32'd3;
      m_epc = cp0.bd_in ? pc - 32'd4 : pc;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | {16'd0, cp0.hw_int, 10'd0};
      if (cp0.exl_clr) m_sr = m_sr & ~32'h2;
      if (cp0.we && cp0.cp0_addr == 5'd12) m_sr = cp0.cp0_wdata & 32'h0000_FC03;
      if (cp0.we && cp0.cp0_addr == 5'd14) m_epc = cp0.cp0_wdata & ~32'd3;
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                        input logic [5:0] hw, input logic clr);
    cp0.we = we;
    cp0.cp0_addr = addr;
    cp0.cp0_wdata = wdata;
    cp0.vpc = vpc;
    cp0.bd_in = bd;
    cp0.exc_code_in = exc;
    cp0.hw_int = hw;
    cp0.exl_clr = clr;
  endtask

  // Checks outputs mid-cycle, then clocks both DUT and model.
  task automatic tick(input string tag);
    @(negedge clk);
    check({tag, "_req"}, {31'd0, cp0.req}, {31'd0, m_req()});
    check({tag, "_epc_out"}, cp0.epc_out, m_epc_out());
    check({tag, "_rdata"}, cp0.cp0_rdata, m_rdata());
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0.cp0_addr = addr;
    #1;
    check(tag, cp0.cp0_rdata, exp);
  endtask

  initial begin
    m_reset();
    set_in(1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    #25;
    check("rst_req", {31'd0, cp0.req}, 32'd0);
    check("rst_epc_out", cp0.epc_out, 32'd0);
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    m_step();
    #1;

    // mtc0 SR then interrupt on line 0
    set_in(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    tick("t2_mtc0");
    set_in(1'b0, 5'd12, 32'h0, 32'h0000_1000, 1'b0, 5'd0, 6'b000001, 1'b0);
    #1 check("t2_req", {31'd0, cp0.req}, 32'd1);
    tick("t2_int");
    rd("t2_sr", 5'd12, 32'h0000_0403);
    rd("t2_cause", 5'd13, 32'h0000_0400);
    rd("t2_epc", 5'd14, 32'h0000_1000);

    // EXL blocks a new exception; eret clears EXL
    cp0.exc_code_in = 5'd12;
    #1 check("t4_req_blocked", {31'd0, cp0.req}, 32'd0);
    tick("t4_blocked");
    rd("t4_epc_kept", 5'd14, 32'h0000_1000);
    cp0.exc_code_in = 5'd0;
    cp0.hw_int = 6'd0;
    cp0.exl_clr = 1'b1;
    tick("t4_eret");
    cp0.exl_clr = 1'b0;
    rd("t4_sr", 5'd12, 32'h0000_0401);

    // AdEL in a delay slot
    set_in(1'b0, 5'd13, 32'h0, 32'h0000_3008, 1'b1, 5'd4, 6'd0, 1'b0);
    tick("t3_exc");
    set_in(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    rd("t3_cause", 5'd13, 32'h8000_0010);
    rd("t3_epc", 5'd14, 32'h0000_3004);
    rd("t3_sr", 5'd12, 32'h0000_0403);

    // mtc0 EPC forwarded to eret in the same cycle
    set_in(1'b1, 5'd14, 32'h0000_3013, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    #1 check("t5_fwd", cp0.epc_out, 32'h0000_3010);
    tick("t5_eret");
    set_in(1'b0, 5'd14, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    rd("t5_epc", 5'd14, 32'h0000_3010);
    rd("t5_sr", 5'd12, 32'h0000_0401);

    // RI wins over a simultaneous mtc0 SR
    set_in(1'b1, 5'd12, 32'h0, 32'h0000_2000, 1'b0, 5'd10, 6'd0, 1'b0);
    #1 check("t6_req", {31'd0, cp0.req}, 32'd1);
    tick("t6_ri");
    set_in(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    rd("t6_sr", 5'd12, 32'h0000_0403);
    rd("t6_cause", 5'd13, 32'h0000_0028);
    rd("t6_prid", 5'd15, 32'h0000_2022);

    // Asynchronous reset mid-handler
    set_in(1'b1, 5'd14, 32'h0000_0044, 32'h0, 1'b0, 5'd5, 6'b111111, 1'b0);
    #1 reset = 1'b0;
    m_reset();
    #1;
    check("t1_req", {31'd0, cp0.req}, 32'd0);
    check("t1_epc_out", cp0.epc_out, 32'd0);
    cp0.we = 1'b0;
    rd("t1_sr", 5'd12, 32'd0);
    rd("t1_cause", 5'd13, 32'd0);
    rd("t1_epc", 5'd14, 32'd0);
    cp0.exc_code_in = 5'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    m_step();
    #1;

    for (int i = 0; i < 400; i++) begin
      logic       we, clr;
      logic [4:0] addr;
      logic [4:0] exc;
      logic [5:0] hw;
      we   = ($urandom_range(0, 3) == 0);
      addr = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                         : 5'($urandom_range(12, 15));
      exc  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      clr  = ($urandom_range(0, 5) == 0);
      if (we && addr == 5'd12) clr = 1'b0;
      set_in(we, addr, $urandom, $urandom, 1'($urandom), exc, hw, clr);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
